// File: rtl/instr_encoder.sv
// Instruction encoder: packs R/I/J-type fields into 32-bit words and streams
// them into instruction memory, one word every two cycles, until finish or full.
module instr_encoder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  input  logic              finish,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   instr_count,
  output logic              full,
  output logic              done,
  output logic              err_illegal,
  output logic [5:0]        bad_opcode,
  output logic [1:0]        state_dbg
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

  // Handshake: a request transfers on any rising edge where in_valid and
  // in_ready are both high; in_ready does not depend on in_valid.

  logic [1:0]  state;
  logic        legal;
  logic [31:0] enc_word;
  logic        accept;

  always_comb begin
    legal    = 1'b0;
    enc_word = 32'h0;
    case (opcode)
      6'b000000, 6'b000001, 6'b000010, 6'b000100, 6'b000101, 6'b000110,
      6'b001000, 6'b001001, 6'b001010, 6'b001011, 6'b010000, 6'b010001,
      6'b010010: begin
        legal    = 1'b1;
        enc_word = {opcode, rd, rs, rt, 11'b0};
      end
      6'b001101, 6'b001110, 6'b001111, 6'b100011, 6'b011111, 6'b101101,
      6'b101110, 6'b100101, 6'b100110, 6'b101000, 6'b101100, 6'b101111: begin
        legal    = 1'b1;
        enc_word = {opcode, rd, rs, imm};
      end
      6'b110000: begin
        legal    = 1'b1;
        enc_word = {opcode, target};
      end
      default: begin
        legal    = 1'b0;
        enc_word = 32'h0;
      end
    endcase
  end

  assign full      = (instr_count == FULL_COUNT);
  assign done      = (state == S_DONE);
  assign imem_we   = (state == S_WRITE);
  assign in_ready  = (state == S_IDLE) && !full && !done;
  assign accept    = in_valid && in_ready;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      imem_addr   <= '0;
      imem_wdata  <= 32'h0;
      instr_count <= '0;
      err_illegal <= 1'b0;
      bad_opcode  <= 6'h0;
    end else begin
      case (state)
        S_IDLE: begin
          // An accepted request outranks finish; when full, in_ready is low so
          // finish is still taken.
          if (accept) begin
            if (legal) begin
              state      <= S_WRITE;
              imem_addr  <= instr_count[ADDR_W-1:0];
              imem_wdata <= enc_word;
            end else begin
              err_illegal <= 1'b1;
              bad_opcode  <= opcode;
            end
          end else if (finish) begin
            state <= S_DONE;
          end
        end
        S_WRITE: begin
          instr_count <= instr_count + 1'b1;
          state       <= S_IDLE;
        end
        S_DONE: state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: vector table, full opcode sweep against a small
// encoding model, and hand-written finish / full / reset-in-write sequences.
module tb_instr_encoder;

  localparam int W = 40;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic        legal;
    logic [31:0] word;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, finish;
  logic [5:0]  opcode;
  logic [4:0]  rd, rs, rt;
  logic [15:0] imm;
  logic [25:0] target;
  logic        in_ready, imem_we, full, done, err_illegal;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0]  instr_count;
  logic [5:0]  bad_opcode;
  logic [1:0]  state_dbg;

  logic        rst2_n, v2, fin2;
  logic [5:0]  op2;
  logic [4:0]  rd2;
  logic        rdy2, we2, full2, done2, err2;
  logic [1:0]  addr2;
  logic [31:0] wdata2;
  logic [2:0]  count2;
  logic [5:0]  bad2;
  logic [1:0]  st2;

  logic [W-1:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          exp_count;
  logic        exp_err;
  logic [5:0]  exp_bad;
  logic [7:0]  last_addr;
  logic [31:0] last_word;
  vec_t        vecs[11];

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs(rs), .rt(rt), .imm(imm), .target(target),
    .finish(finish), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .instr_count(instr_count), .full(full),
    .done(done), .err_illegal(err_illegal), .bad_opcode(bad_opcode),
    .state_dbg(state_dbg)
  );

  instr_encoder #(.ADDR_W(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .in_valid(v2), .in_ready(rdy2),
    .opcode(op2), .rd(rd2), .rs(5'd0), .rt(5'd0), .imm(16'h0), .target(26'h0),
    .finish(fin2), .imem_we(we2), .imem_addr(addr2), .imem_wdata(wdata2),
    .instr_count(count2), .full(full2), .done(done2), .err_illegal(err2),
    .bad_opcode(bad2), .state_dbg(st2)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [32:0] model_encode(input vec_t v);
    if (v.op inside {6'o00, 6'o01, 6'o02, 6'o04, 6'o05, 6'o06, 6'o10, 6'o11,
                     6'o12, 6'o13, 6'o20, 6'o21, 6'o22})
      return {1'b1, v.op, v.rd, v.rs, v.rt, 11'b0};
    if (v.op inside {6'o15, 6'o16, 6'o17, 6'o43, 6'o37, 6'o55, 6'o56, 6'o45,
                     6'o46, 6'o50, 6'o54, 6'o57})
      return {1'b1, v.op, v.rd, v.rs, v.imm};
    if (v.op == 6'o60)
      return {1'b1, v.op, v.tgt};
    return {1'b0, 32'h0};
  endfunction

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (imem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {24'h0, imem_addr, imem_wdata}, 64'h0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("write_addr_data", {24'h0, imem_addr, imem_wdata}, {24'h0, e});
      end
    end
  end

  task automatic send(input vec_t v, input logic fin);
    int waited = 0;
    @(negedge clk);
    opcode = v.op; rd = v.rd; rs = v.rs; rt = v.rt; imm = v.imm; target = v.tgt;
    in_valid = 1'b1;
    finish = fin;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("handshake_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      finish = 1'b0;
      return;
    end
    if (v.legal) begin
      exp_q.push_back({exp_count[7:0], v.word});
      last_addr = exp_count[7:0];
      last_word = v.word;
    end else begin
      exp_err = 1'b1;
      exp_bad = v.op;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    finish = 1'b0;
    if (v.legal) begin
      check("ready_low_in_write", {63'h0, in_ready}, 64'd0);
      @(negedge clk);
      exp_count++;
    end else begin
      check("no_write_on_illegal", {63'h0, imem_we}, 64'd0);
    end
    check("ready_back_high", {63'h0, in_ready}, 64'd1);
    check("instr_count", {55'h0, instr_count}, 64'(exp_count));
    check("err_illegal", {63'h0, err_illegal}, {63'h0, exp_err});
    check("bad_opcode", {58'h0, bad_opcode}, {58'h0, exp_bad});
    check("done_low", {63'h0, done}, 64'd0);
    check("held_addr_data", {24'h0, imem_addr, imem_wdata}, {24'h0, last_addr, last_word});
  endtask

  initial begin
    vec_t v;
    logic [32:0] m;

    vecs[0]  = '{6'o00, 5'd3,  5'd1,  5'd2,  16'hFFFF, 26'h3FFFFFF, 1'b1, 32'h00611000};
    vecs[1]  = '{6'o15, 5'd4,  5'd0,  5'd31, 16'h0005, 26'h1555555, 1'b1, 32'h34800005};
    vecs[2]  = '{6'o60, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h0000010, 1'b1, 32'hC0000010};
    vecs[3]  = '{6'o77, 5'd1,  5'd2,  5'd3,  16'h1234, 26'h0000001, 1'b0, 32'h0};
    vecs[4]  = '{6'o22, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 1'b1, 32'h4BFFF800};
    vecs[5]  = '{6'o57, 5'd1,  5'd2,  5'd9,  16'hABCD, 26'h2AAAAAA, 1'b1, 32'hBC22ABCD};
    vecs[6]  = '{6'o03, 5'd1,  5'd1,  5'd1,  16'h0001, 26'h0000001, 1'b0, 32'h0};
    vecs[7]  = '{6'o43, 5'd0,  5'd31, 5'd4,  16'h8000, 26'h0000000, 1'b1, 32'h8C1F8000};
    vecs[8]  = '{6'o13, 5'd5,  5'd6,  5'd7,  16'hFFFF, 26'h3FFFFFF, 1'b1, 32'h2CA63800};
    vecs[9]  = '{6'o61, 5'd2,  5'd2,  5'd2,  16'h0002, 26'h0000002, 1'b0, 32'h0};
    vecs[10] = '{6'o37, 5'd2,  5'd3,  5'd0,  16'h1234, 26'h0000000, 1'b1, 32'h7C431234};

    rst_n = 1'b0; in_valid = 1'b0; finish = 1'b0;
    opcode = 6'h0; rd = 5'h0; rs = 5'h0; rt = 5'h0; imm = 16'h0; target = 26'h0;
    rst2_n = 1'b0; v2 = 1'b0; fin2 = 1'b0; op2 = 6'h0; rd2 = 5'h0;
    exp_count = 0; exp_err = 1'b0; exp_bad = 6'h0; last_addr = 8'h0; last_word = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {20'h0, imem_we, imem_addr, imem_wdata, full, done, err_illegal, bad_opcode},
          64'h0);
    check("reset_count", {55'h0, instr_count}, 64'd0);
    rst_n = 1'b1;
    rst2_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {63'h0, in_ready}, 64'd1);

    foreach (vecs[i]) send(vecs[i], 1'b0);

    for (int op = 0; op < 64; op++) begin
      v.op = 6'(op);
      v.rd = 5'($urandom_range(0, 31));
      v.rs = 5'($urandom_range(0, 31));
      v.rt = 5'($urandom_range(0, 31));
      v.imm = 16'($urandom_range(0, 65535));
      v.tgt = {10'($urandom_range(0, 1023)), 16'($urandom_range(0, 65535))};
      m = model_encode(v);
      v.legal = m[32];
      v.word = m[31:0];
      send(v, 1'b0);
    end

    // Request and finish together: the request wins, then finish alone closes.
    send(vecs[1], 1'b1);
    @(negedge clk);
    finish = 1'b1;
    @(posedge clk);
    @(negedge clk);
    finish = 1'b0;
    check("done_after_finish", {62'h0, done, in_ready}, 64'd2);
    opcode = 6'o00; in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("done_ignores_input", {54'h0, done, in_ready, instr_count}, {54'h0, 1'b1, 1'b0, 9'(exp_count)});
    end
    in_valid = 1'b0;

    // Reset during a WRITE cycle: the strobe of that cycle is already visible,
    // but nothing further is written and the count returns to zero.
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = 0; exp_err = 1'b0; exp_bad = 6'h0;
    check("reset_clears_done", {62'h0, done, in_ready}, 64'd1);
    opcode = 6'o00; rd = 5'd3; rs = 5'd1; rt = 5'd2; in_valid = 1'b1;
    exp_q.push_back({8'h00, 32'h00611000});
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("reset_in_write",
          {20'h0, imem_we, imem_addr, imem_wdata, full, done, err_illegal, bad_opcode},
          64'h0);
    check("reset_in_write_count", {55'h0, instr_count}, 64'd0);
    @(negedge clk);
    check("no_count_after_abort", {54'h0, imem_we, in_ready, instr_count}, {54'h0, 1'b0, 1'b1, 9'd0});

    // ADDR_W=2: fill all four words, then nothing more is accepted.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      op2 = 6'o00; rd2 = 5'(i + 1); v2 = 1'b1;
      check("small_ready", {63'h0, rdy2}, 64'd1);
      @(posedge clk);
      @(negedge clk);
      v2 = 1'b0;
      check("small_write", {29'h0, we2, addr2, wdata2}, {29'h0, 1'b1, 2'(i), 32'(i + 1) << 21});
      @(negedge clk);
    end
    check("small_full", {58'h0, full2, rdy2, 1'b0, count2}, {58'h0, 1'b1, 1'b0, 1'b0, 3'd4});
    v2 = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("small_no_write_when_full", {61'h0, we2, count2[2], addr2 == 2'd3}, {61'h0, 1'b0, 1'b1, 1'b1});
    end
    fin2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fin2 = 1'b0; v2 = 1'b0;
    check("small_finish_when_full", {62'h0, done2, rdy2}, 64'd2);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
